spi_cmd_frontend: RTL and testbench
===================================

SPI_CMD_FRONTEND -- requirements
Module: spi_cmd_frontend

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, at least 2.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per SPI input.
REQ-003 clk  input  1  system clock; all state is clocked on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 spi_sclk  input  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 spi_mosi  input  1  SPI data from host, MSB first.
REQ-008 spi_miso  output  1  SPI data to host, MSB first.
REQ-009 out_valid  output  1  received byte available; drives command-decoder cmd_in_valid.
REQ-010 out_ready  input  1  downstream accepts byte.
REQ-011 out_data  output  8  received byte (byte_t).
REQ-012 rsp_valid  input  1  response byte offered by command decoder (cmd_out_valid).
REQ-013 rsp_ready  output  1  response byte taken; single-cycle pulse.
REQ-014 rsp_data  input  8  response byte (cmd_out_data).
REQ-015 overflow  output  1  sticky: a received byte was dropped.
REQ-016 overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-017 spi_sclk, spi_cs_n and spi_mosi shall each pass through SYNC_STAGES flops; all logic uses only synchronized copies; cs_n synchronizer resets to 1, others to 0.
REQ-018 Host SCLK shall not exceed clk/8, with high and low phases each at least 3 clk periods.
REQ-019 Edge detect: rise = sync sclk 0->1, fall = 1->0, cs_start = sync cs_n 1->0, cs_end = sync cs_n 0->1.
REQ-020 States: IDLE (cs inactive) and ACTIVE (cs asserted); IDLE->ACTIVE on cs_start; ACTIVE->IDLE on cs_end; sclk edges in IDLE are ignored.
REQ-021 On each rise in ACTIVE, sync mosi shifts into rx_shift LSB side; 3-bit bit_cnt increments and wraps 7->0.
REQ-022 Rise with bit_cnt==7 completes a byte {rx_shift[6:0], mosi}, pushed to FIFO the same cycle.
REQ-023 cs_end with bit_cnt!=0 discards the partial byte; bit_cnt and rx_shift clear to 0; the FIFO is untouched.
REQ-024 FIFO: first-word-fall-through; out_valid = not empty; out_data = head entry; pop on out_valid && out_ready.
REQ-025 Latency: a pushed byte appears on out_valid/out_data on the next clk cycle when the FIFO was empty.
REQ-026 Push with FIFO full and no pop in the same cycle drops the byte, FIFO unchanged, overflow <= 1.
REQ-027 Push and pop in the same cycle when full are both accepted; count stays FIFO_DEPTH; no overflow.
REQ-028 Push and pop in the same cycle when empty is impossible (out_valid=0); the byte is stored.
REQ-029 Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-030 overflow: set has priority over overflow_clr in the same cycle.
REQ-031 TX load occurs on cs_start and on every byte completion (REQ-022): tx_shift <= rsp_data with rsp_ready=1 for one cycle if rsp_valid, else 0x00 with rsp_ready=0.
REQ-032 On each fall in ACTIVE, tx_shift shifts left by 1 with 0 fill; spi_miso = tx_shift[7] registered in ACTIVE, 0 in IDLE.
REQ-033 rsp_ready shall never assert outside ACTIVE and shall never pulse twice per byte slot.

Reset
REQ-034 rstn low asynchronously forces: state IDLE, bit_cnt 0, rx_shift 0, tx_shift 0, FIFO empty, out_valid 0, out_data 0x00, spi_miso 0, rsp_ready 0, overflow 0.
REQ-035 Reset mid-transfer discards all buffered and partial bytes; after release, reception starts only on a fresh cs_start.

Verification
REQ-036 cs low, send 0xA0 then 0x05 with SCLK=clk/8, out_ready=1 -> out_data 0xA0 then 0x05, one out_valid pulse each, overflow 0.
REQ-037 out_ready=0, send FIFO_DEPTH+1 = 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, overflow=1; then out_ready=1 -> 0x01..0x04 drain in order, 0x05 never appears.
REQ-038 Send 5 bits, raise cs, then a new frame with 0xB0 -> only 0xB0 is output.
REQ-039 rsp_valid=1, rsp_data=0x3C held before cs_start -> rsp_ready pulses once at cs_start; MISO bits of first byte = 0,0,1,1,1,1,0,0; with rsp_valid=0 the next byte reads 0x00.
REQ-040 Assert rstn low mid-byte with 2 bytes queued -> out_valid 0 immediately; overflow 0; next frame 0xA1 is received correctly.
REQ-041 FIFO full with out_ready=1 and a byte completing in the same cycle -> no overflow, byte stored, order preserved.

Source files
------------

// File: rtl/spi_cmd_frontend_if.sv
// Bus bundle for spi_cmd_frontend: SPI pins, receive-byte stream,
// response-byte handshake and overflow status.
// The slave modport is the frontend itself; master is whatever drives it
// (SPI host side plus the command decoder).
interface spi_cmd_frontend_if;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       overflow;
   logic       overflow_clr;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, out_ready, rsp_valid, rsp_data, overflow_clr,
      output spi_miso, out_valid, out_data, rsp_ready, overflow
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, out_ready, rsp_valid, rsp_data, overflow_clr,
      input  spi_miso, out_valid, out_data, rsp_ready, overflow
   );
endinterface

// File: rtl/spi_cmd_frontend.sv
// SPI mode-0 slave frontend. SPI pins are oversampled in the clk domain
// through synchronizers; received bytes go into a first-word-fall-through
// FIFO, and response bytes from the command decoder are shifted out on MISO.
module spi_cmd_frontend #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rstn,
   spi_cmd_frontend_if.slave  io_bus
);
   typedef logic [7:0] byte_t;
   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   // ---------------------------------------------------------------
   // Input synchronizers and edge detection
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_q;
   logic                   r_cs_q;

   logic w_sclk, w_cs_n, w_mosi;
   logic w_rise, w_fall, w_cs_start, w_cs_end;

   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // Synchronize SPI pins; cs_n idles high so its chain resets to 1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_q    <= 1'b0;
         r_cs_q      <= 1'b1;
      end else begin
         r_sclk_sync[0] <= io_bus.spi_sclk;
         r_cs_sync[0]   <= io_bus.spi_cs_n;
         r_mosi_sync[0] <= io_bus.spi_mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sclk_sync[i] <= r_sclk_sync[i-1];
            r_cs_sync[i]   <= r_cs_sync[i-1];
            r_mosi_sync[i] <= r_mosi_sync[i-1];
         end
         r_sclk_q <= w_sclk;
         r_cs_q   <= w_cs_n;
      end
   end

   assign w_rise     =  w_sclk & ~r_sclk_q;
   assign w_fall     = ~w_sclk &  r_sclk_q;
   assign w_cs_start = ~w_cs_n &  r_cs_q;
   assign w_cs_end   =  w_cs_n & ~r_cs_q;

   // ---------------------------------------------------------------
   // Transfer FSM: RX shift, TX shift, response handshake
   // ---------------------------------------------------------------
   state_t      r_state;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_rx_shift;
   byte_t       r_tx_shift;
   logic        r_rsp_ready;

   logic  w_active;
   logic  w_push;
   byte_t w_rx_byte;
   byte_t w_tx_load;

   assign w_active  = (r_state == S_ACTIVE);
   assign w_rx_byte = {r_rx_shift, w_mosi};
   // A byte completes on the 8th rise; a simultaneous cs_end wins.
   assign w_push    = w_active && !w_cs_end && w_rise && (r_bit_cnt == 3'd7);
   assign w_tx_load = io_bus.rsp_valid ? io_bus.rsp_data : 8'h00;

   // Frame state, bit counting, and MISO byte loading/shifting.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_rsp_ready <= 1'b0;
      end else begin
         r_rsp_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cs_start) begin
                  r_state     <= S_ACTIVE;
                  r_bit_cnt   <= 3'd0;
                  r_rx_shift  <= '0;
                  r_tx_shift  <= w_tx_load;
                  r_rsp_ready <= io_bus.rsp_valid;
               end
            end
            S_ACTIVE: begin
               if (w_cs_end) begin
                  // Partial byte is dropped; tx top bit cleared so MISO idles low.
                  r_state    <= S_IDLE;
                  r_bit_cnt  <= 3'd0;
                  r_rx_shift <= '0;
                  r_tx_shift <= '0;
               end else if (w_rise) begin
                  r_rx_shift <= w_rx_byte[6:0];
                  r_bit_cnt  <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_tx_shift  <= w_tx_load;
                     r_rsp_ready <= io_bus.rsp_valid;
                  end
               end else if (w_fall && (r_bit_cnt != 3'd0)) begin
                  // The fall right after a byte boundary would push out the
                  // freshly loaded MSB before the host sampled it, so skip it.
                  r_tx_shift <= {r_tx_shift[6:0], 1'b0};
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.spi_miso  = r_tx_shift[7];
   assign io_bus.rsp_ready = r_rsp_ready;

   // ---------------------------------------------------------------
   // Receive FIFO (first-word-fall-through)
   // ---------------------------------------------------------------
   byte_t          r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_overflow;

   logic w_full, w_empty, w_pop, w_wr_en;

   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && io_bus.out_ready;
   // When full, a same-cycle pop frees the head slot for the new byte.
   assign w_wr_en = w_push && (!w_full || w_pop);

   // Storage write; no reset needed since reads are gated by count.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= w_rx_byte;
   end

   // Pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
         else if (io_bus.overflow_clr)   r_overflow <= 1'b0;
      end
   end

   assign io_bus.out_valid = !w_empty;
   assign io_bus.out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign io_bus.overflow  = r_overflow;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Self-checking bench for spi_cmd_frontend: table of single-byte frames,
// hand-written corner sequences, and randomized frames against a
// byte-level reference model.
module tb_spi_cmd_frontend;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   spi_cmd_frontend_if bus();

   spi_cmd_frontend #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .io_bus (bus.slave)
   );

   always #5 clk = ~clk;

   // out_ready either follows the sequence (rdy) or toggles randomly.
   logic rdy      = 1'b0;
   logic rnd_mode = 1'b0;
   logic rnd_bit  = 1'b0;
   assign bus.out_ready = rnd_mode ? rnd_bit : rdy;

   // Random ready pattern.
   always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

   // Monitor: record every byte popped and every rsp_ready pulse.
   logic [7:0] got_q[$];
   int         rsp_pulses = 0;
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
         if (bus.rsp_ready) rsp_pulses <= rsp_pulses + 1;
      end
   end

   int checks = 0;
   int errors = 0;
   int rd_idx = 0;

   // Frame description shared by send_frame and the tests.
   logic [7:0] f_mosi [0:8];
   logic       f_rv   [0:9];
   logic [7:0] f_rd   [0:9];
   logic [7:0] f_miso [0:8];

   typedef struct {
      logic [7:0] mosi;
      logic       rv;
      logic [7:0] rd;
      logic [7:0] exp_out;
      logic [7:0] exp_miso;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Compare the next popped byte against an expected value.
   task automatic expect_got(input string name, input logic [7:0] e);
      if (rd_idx < got_q.size()) begin
         chk(name, {24'h0, got_q[rd_idx]}, {24'h0, e});
         rd_idx++;
      end else begin
         chk({name, "_missing"}, 32'hFFFF_FFFF, {24'h0, e});
      end
   endtask

   // Wait (bounded) until n more bytes have been popped.
   task automatic wait_bytes(input int n);
      int t = 0;
      while ((got_q.size() - rd_idx) < n && t < 400) begin
         clks(1);
         t++;
      end
   endtask

   // One mode-0 host transaction: nb full bytes then `part` extra bits.
   // Response for slot k+1 is presented mid-way through byte k.
   task automatic send_frame(input int nb, input int part, input logic pulse_last);
      logic [7:0] m;
      int nbits;
      m = 8'h00;
      bus.rsp_valid = f_rv[0];
      bus.rsp_data  = f_rd[0];
      bus.spi_cs_n  = 1'b0;
      clks(6);
      for (int k = 0; k < nb + ((part > 0) ? 1 : 0); k++) begin
         nbits = (k < nb) ? 8 : part;
         for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = f_mosi[k][7-i];
            clks(4);
            m[7-i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            if (pulse_last && k == nb - 1 && i == 7) begin
               // Make out_ready coincide with the cycle the byte is pushed.
               clks(SYNC);
               rdy = 1'b1;
               clks(1);
               rdy = 1'b0;
               clks(4 - SYNC - 1);
            end else begin
               clks(4);
            end
            bus.spi_sclk = 1'b0;
            if (i == 3) begin
               bus.rsp_valid = f_rv[k+1];
               bus.rsp_data  = f_rd[k+1];
            end
         end
         f_miso[k] = m;
      end
      clks(4);
      bus.spi_cs_n  = 1'b1;
      bus.rsp_valid = 1'b0;
      clks(10);
   endtask

   task automatic clear_rsp();
      for (int i = 0; i < 10; i++) begin
         f_rv[i] = 1'b0;
         f_rd[i] = 8'h00;
      end
   endtask

   initial begin
      int p0, nb, part, exp_pulses;
      logic [7:0] exp_bytes[$];
      logic [7:0] exp_miso[$];

      vecs[0] = '{8'hA5, 1'b1, 8'h5A, 8'hA5, 8'h5A};
      vecs[1] = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 8'h81, 8'hFF, 8'h81};
      vecs[3] = '{8'h3C, 1'b1, 8'h00, 8'h3C, 8'h00};
      vecs[4] = '{8'h80, 1'b0, 8'h7E, 8'h80, 8'h00};
      vecs[5] = '{8'h01, 1'b1, 8'hC3, 8'h01, 8'hC3};

      bus.spi_sclk     = 1'b0;
      bus.spi_cs_n     = 1'b1;
      bus.spi_mosi     = 1'b0;
      bus.rsp_valid    = 1'b0;
      bus.rsp_data     = 8'h00;
      bus.overflow_clr = 1'b0;
      clear_rsp();

      // Reset state
      clks(3);
      chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
      chk("rst_out_data",  {24'h0, bus.out_data}, 0);
      chk("rst_miso",      {31'h0, bus.spi_miso}, 0);
      chk("rst_rsp_ready", {31'h0, bus.rsp_ready}, 0);
      chk("rst_overflow",  {31'h0, bus.overflow}, 0);
      rstn = 1'b1;
      clks(4);

      // Table: single-byte frames, received byte and MISO byte
      rdy = 1'b1;
      foreach (vecs[v]) begin
         clear_rsp();
         f_mosi[0] = vecs[v].mosi;
         f_rv[0]   = vecs[v].rv;
         f_rd[0]   = vecs[v].rd;
         send_frame(1, 0, 1'b0);
         wait_bytes(1);
         expect_got($sformatf("tbl%0d_out", v), vecs[v].exp_out);
         chk($sformatf("tbl%0d_miso", v), {24'h0, f_miso[0]}, {24'h0, vecs[v].exp_miso});
      end

      // Two bytes in one frame
      clear_rsp();
      f_mosi[0] = 8'hA0;
      f_mosi[1] = 8'h05;
      send_frame(2, 0, 1'b0);
      wait_bytes(2);
      expect_got("two_b0", 8'hA0);
      expect_got("two_b1", 8'h05);
      chk("two_extra", got_q.size() - rd_idx, 0);
      chk("two_ovf", {31'h0, bus.overflow}, 0);

      // Overflow: five bytes into a four-deep FIFO with no reader
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) f_mosi[i] = 8'(i + 1);
      send_frame(5, 0, 1'b0);
      chk("ovf_set",   {31'h0, bus.overflow}, 1);
      chk("ovf_valid", {31'h0, bus.out_valid}, 1);
      chk("ovf_head",  {24'h0, bus.out_data}, 32'h01);
      rdy = 1'b1;
      clks(12);
      for (int i = 0; i < 4; i++) expect_got($sformatf("ovf_drain%0d", i), 8'(i + 1));
      chk("ovf_no5", got_q.size() - rd_idx, 0);
      chk("ovf_sticky", {31'h0, bus.overflow}, 1);
      bus.overflow_clr = 1'b1;
      clks(1);
      bus.overflow_clr = 1'b0;
      chk("ovf_clr", {31'h0, bus.overflow}, 0);

      // Full FIFO, pop and push in the same cycle
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) f_mosi[i] = 8'(8'h11 + i);
      send_frame(4, 0, 1'b0);
      chk("full_head", {24'h0, bus.out_data}, 32'h11);
      f_mosi[0] = 8'h15;
      send_frame(1, 0, 1'b1);
      chk("full_noovf", {31'h0, bus.overflow}, 0);
      rdy = 1'b1;
      clks(12);
      for (int i = 0; i < 5; i++) expect_got($sformatf("full_ord%0d", i), 8'(8'h11 + i));

      // Partial byte discarded, next frame received
      f_mosi[0] = 8'hFF;
      send_frame(0, 5, 1'b0);
      chk("part_none", got_q.size() - rd_idx, 0);
      f_mosi[0] = 8'hB0;
      send_frame(1, 0, 1'b0);
      wait_bytes(1);
      expect_got("part_b0", 8'hB0);
      chk("part_extra", got_q.size() - rd_idx, 0);

      // MISO response and single rsp_ready pulse
      clear_rsp();
      f_rv[0] = 1'b1;
      f_rd[0] = 8'h3C;
      f_rd[1] = 8'hFF;
      f_mosi[0] = 8'h5A;
      f_mosi[1] = 8'h66;
      p0 = rsp_pulses;
      send_frame(2, 0, 1'b0);
      chk("miso_b0", {24'h0, f_miso[0]}, 32'h3C);
      chk("miso_b1", {24'h0, f_miso[1]}, 32'h00);
      chk("miso_pulses", rsp_pulses - p0, 1);
      wait_bytes(2);
      expect_got("miso_rx0", 8'h5A);
      expect_got("miso_rx1", 8'h66);

      // Reset mid-byte with two bytes queued
      rdy = 1'b0;
      f_mosi[0] = 8'hC1;
      f_mosi[1] = 8'hC2;
      send_frame(2, 0, 1'b0);
      chk("mrst_queued", {31'h0, bus.out_valid}, 1);
      bus.spi_cs_n = 1'b0;
      clks(6);
      for (int i = 0; i < 3; i++) begin
         bus.spi_mosi = 1'b1;
         clks(4);
         bus.spi_sclk = 1'b1;
         clks(4);
         bus.spi_sclk = 1'b0;
      end
      #3 rstn = 1'b0;
      #1;
      chk("mrst_valid", {31'h0, bus.out_valid}, 0);
      chk("mrst_ovf",   {31'h0, bus.overflow}, 0);
      chk("mrst_miso",  {31'h0, bus.spi_miso}, 0);
      bus.spi_cs_n = 1'b1;
      clks(3);
      rstn = 1'b1;
      rdy  = 1'b1;
      clks(5);
      f_mosi[0] = 8'hA1;
      send_frame(1, 0, 1'b0);
      wait_bytes(1);
      expect_got("mrst_a1", 8'hA1);
      chk("mrst_extra", got_q.size() - rd_idx, 0);

      // Randomized frames against the reference model
      rnd_mode = 1'b1;
      for (int f = 0; f < 20; f++) begin
         nb   = $urandom_range(1, 3);
         part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < 10; i++) begin
            f_rv[i] = 1'($urandom_range(0, 1));
            f_rd[i] = 8'($urandom);
         end
         for (int i = 0; i < 9; i++) f_mosi[i] = 8'($urandom);
         exp_bytes.delete();
         exp_miso.delete();
         exp_pulses = 0;
         // Model: each completed byte is delivered; slot k of the frame
         // returns the response offered at its start (0 if none offered).
         for (int k = 0; k < nb; k++) begin
            exp_bytes.push_back(f_mosi[k]);
            exp_miso.push_back(f_rv[k] ? f_rd[k] : 8'h00);
         end
         for (int k = 0; k <= nb; k++) exp_pulses += f_rv[k] ? 1 : 0;
         p0 = rsp_pulses;
         send_frame(nb, part, 1'b0);
         wait_bytes(nb);
         for (int k = 0; k < nb; k++) begin
            expect_got($sformatf("rnd%0d_rx%0d", f, k), exp_bytes[k]);
            chk($sformatf("rnd%0d_miso%0d", f, k), {24'h0, f_miso[k]}, {24'h0, exp_miso[k]});
         end
         chk($sformatf("rnd%0d_pulses", f), rsp_pulses - p0, exp_pulses);
         chk($sformatf("rnd%0d_extra", f), got_q.size() - rd_idx, 0);
      end
      rnd_mode = 1'b0;
      chk("rnd_ovf", {31'h0, bus.overflow}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
